// File: rtl/piso_stream.sv
// Parallel-in/serial-out shifter with valid/ready load, one-word holding buffer
// and frame markers. Define PISO_PARITY_EN to append an even-parity bit to each frame.
module piso_stream #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_first,
   output logic             ser_last,
   output logic             busy
);

`ifdef PISO_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif
   localparam int CNT_W = $clog2(FRAME);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

   typedef enum logic {
      S_IDLE,
      S_SHIFT
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [WIDTH-1:0]   hold_q, hold_d;
   logic               hold_full_q, hold_full_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef PISO_PARITY_EN
   logic               par_q, par_d;
`endif

   logic accept;
   logic cnt_last;
   logic cur_bit;

   function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
      if (MSB_FIRST) return {v[WIDTH-2:0], 1'b0};
      else           return {1'b0, v[WIDTH-1:1]};
   endfunction

   assign in_ready = !rst && !hold_full_q;
   assign accept   = in_valid && in_ready;
   assign cnt_last = (cnt_q == LAST_CNT);

   always_comb begin
      cur_bit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
`ifdef PISO_PARITY_EN
      if (cnt_last) cur_bit = par_q;
`endif
   end

   assign ser_valid = (state_q == S_SHIFT);
   assign ser_out   = ser_valid && cur_bit;
   assign ser_first = ser_valid && (cnt_q == '0);
   assign ser_last  = ser_valid && cnt_last;
   assign busy      = (state_q == S_SHIFT) || hold_full_q;

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      cnt_d       = cnt_q;
`ifdef PISO_PARITY_EN
      par_d       = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               shift_d = in_data;
               cnt_d   = '0;
               state_d = S_SHIFT;
`ifdef PISO_PARITY_EN
               par_d   = ^in_data;
`endif
            end
         end
         S_SHIFT: begin
            if (cnt_last) begin
               // Frame boundary: held word has priority; in_ready is low while it exists
               if (hold_full_q) begin
                  shift_d     = hold_q;
                  hold_full_d = 1'b0;
                  cnt_d       = '0;
`ifdef PISO_PARITY_EN
                  par_d       = ^hold_q;
`endif
               end else if (accept) begin
                  shift_d = in_data;
                  cnt_d   = '0;
`ifdef PISO_PARITY_EN
                  par_d   = ^in_data;
`endif
               end else begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end
            end else begin
               shift_d = shift_one(shift_q);
               cnt_d   = cnt_q + CNT_W'(1);
               if (accept) begin
                  hold_d      = in_data;
                  hold_full_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         cnt_q       <= '0;
`ifdef PISO_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         cnt_q       <= cnt_d;
`ifdef PISO_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_piso_stream.sv
// Scoreboard bench for piso_stream (WIDTH=4): one MSB-first and one LSB-first instance.
// Expected serial bits are pushed per accepted word; a negedge monitor pops and compares.
module tb_piso_stream;
   localparam int W = 4;
`ifdef PISO_PARITY_EN
   localparam int FRAME = 5;
`else
   localparam int FRAME = 4;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [W-1:0] in_data_m = '0, in_data_l = '0;
   logic in_valid_m = 1'b0, in_valid_l = 1'b0;
   logic in_ready_m, ser_out_m, ser_valid_m, ser_first_m, ser_last_m, busy_m;
   logic in_ready_l, ser_out_l, ser_valid_l, ser_first_l, ser_last_l, busy_l;

   piso_stream #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .in_data(in_data_m), .in_valid(in_valid_m), .in_ready(in_ready_m),
      .ser_out(ser_out_m), .ser_valid(ser_valid_m), .ser_first(ser_first_m),
      .ser_last(ser_last_m), .busy(busy_m));

   piso_stream #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .in_data(in_data_l), .in_valid(in_valid_l), .in_ready(in_ready_l),
      .ser_out(ser_out_l), .ser_valid(ser_valid_l), .ser_first(ser_first_l),
      .ser_last(ser_last_l), .busy(busy_l));

   // b: bit, f: first, l: last, c: must follow the previous bit with no gap
   typedef struct packed {logic b; logic f; logic l; logic c;} exp_t;
   exp_t q_m[$];
   exp_t q_l[$];

   int  n_vec = 0;
   int  n_fail = 0;
   int  cyc = 0;
   int  last_pop [2];
   bit  mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int id, input exp_t e);
      if (id == 0) q_m.push_back(e);
      else         q_l.push_back(e);
   endtask

   // seq lists the expected serial bits in emission order, leftmost first
   task automatic send(input int id, input logic [W-1:0] d, input logic [W-1:0] seq,
                       input logic par, input bit contig);
      exp_t e;
      int   n;
      for (int i = 0; i < W; i++) begin
         e.b = seq[W-1-i];
         e.f = (i == 0);
         e.l = (i == W-1) && (FRAME == W);
         e.c = (i != 0) || contig;
         push(id, e);
      end
`ifdef PISO_PARITY_EN
      e.b = par; e.f = 1'b0; e.l = 1'b1; e.c = 1'b1;
      push(id, e);
`endif
      @(negedge clk);
      if (id == 0) begin in_data_m = d; in_valid_m = 1'b1; end
      else         begin in_data_l = d; in_valid_l = 1'b1; end
      n = 0;
      while (((id == 0) ? in_ready_m : in_ready_l) !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         n_vec++;
         n_fail++;
         $display("FAIL accept_timeout: dut %0d word %0h not accepted in 50 cycles", id, d);
      end
      @(posedge clk);
      #1;
      if (id == 0) in_valid_m = 1'b0;
      else         in_valid_l = 1'b0;
   endtask

   task automatic mon(input int id, input logic v, input logic o, input logic f, input logic l);
      exp_t e;
      if (v !== 1'b1) begin
         check($sformatf("idle_out%0d", id), {v, o}, 2'b00);
         return;
      end
      if ((id == 0 ? q_m.size() : q_l.size()) == 0) begin
         n_vec++;
         n_fail++;
         $display("FAIL extra_bit: dut %0d emitted unexpected bit %0b", id, o);
         return;
      end
      e = (id == 0) ? q_m.pop_front() : q_l.pop_front();
      check($sformatf("bit%0d{out,first,last}", id), {o, f, l}, {e.b, e.f, e.l});
      if (e.c && last_pop[id] != cyc - 1) begin
         n_vec++;
         n_fail++;
         $display("FAIL gap%0d: bit at cycle %0d, previous at %0d, required contiguous",
                  id, cyc, last_pop[id]);
      end
      last_pop[id] = cyc;
   endtask

   always @(negedge clk) begin
      cyc++;
      if (mon_en) begin
         mon(0, ser_valid_m, ser_out_m, ser_first_m, ser_last_m);
         mon(1, ser_valid_l, ser_out_l, ser_first_l, ser_last_l);
      end
   end

   initial begin
      int n;
      last_pop[0] = -10;
      last_pop[1] = -10;

      // Reset state
      @(posedge clk);
      #1 mon_en = 1'b1;
      @(negedge clk);
      check("rst_in_ready_m", in_ready_m, 1'b0);
      check("rst_in_ready_l", in_ready_l, 1'b0);
      check("rst_busy_m", busy_m, 1'b0);
      check("rst_valid_m", ser_valid_m, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_rst", in_ready_m, 1'b1);

      // 1: single word 4'hC, MSB first
      send(0, 4'hC, 4'b1100, 1'b0, 1'b0);
      repeat (FRAME + 1) @(negedge clk);
      check("t1_valid_after_frame", ser_valid_m, 1'b0);
      check("t1_busy_after_frame", busy_m, 1'b0);

      // 2: back-to-back C then F, F held while C shifts
      send(0, 4'hC, 4'b1100, 1'b0, 1'b0);
      send(0, 4'hF, 4'b1111, 1'b0, 1'b1);
      @(negedge clk);
      check("t2_in_ready_held", in_ready_m, 1'b0);
      check("t2_busy_held", busy_m, 1'b1);
      repeat (2 * FRAME + 2) @(negedge clk);
      check("t2_busy_done", busy_m, 1'b0);

      // 3: LSB first, 5 then 1
      send(1, 4'h5, 4'b1010, 1'b0, 1'b0);
      send(1, 4'h1, 4'b1000, 1'b1, 1'b1);

      // 6: stream 0,5,1,7 gap-free on the MSB-first instance
      send(0, 4'h0, 4'b0000, 1'b0, 1'b0);
      send(0, 4'h5, 4'b0101, 1'b0, 1'b1);
      send(0, 4'h1, 4'b0001, 1'b1, 1'b1);
      send(0, 4'h7, 4'b0111, 1'b1, 1'b1);
      repeat (3 * FRAME) @(negedge clk);

      // 5: parity words (parity bit only expected when enabled)
      send(0, 4'h7, 4'b0111, 1'b1, 1'b0);
      send(0, 4'h5, 4'b0101, 1'b0, 1'b1);
      repeat (3 * FRAME) @(negedge clk);
      check("t5_idle", busy_m, 1'b0);

      // 4: reset after two bits of F with 7 held
      send(0, 4'hF, 4'b1111, 1'b0, 1'b0);
      send(0, 4'h7, 4'b0111, 1'b1, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      q_m.delete();
      @(negedge clk);
      check("t4_rst_outs{v,o,f,l,busy}",
            {ser_valid_m, ser_out_m, ser_first_m, ser_last_m, busy_m}, 5'b0);
      check("t4_rst_in_ready", in_ready_m, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("t4_in_ready_after", in_ready_m, 1'b1);
      send(0, 4'h0, 4'b0000, 1'b0, 1'b0);

      // Drain and confirm nothing remains or follows
      n = 0;
      while ((q_m.size() != 0 || q_l.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (FRAME + 2) @(negedge clk);
      check("drain_q_m", q_m.size(), 0);
      check("drain_q_l", q_l.size(), 0);
      check("final_busy", {busy_m, busy_l}, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
